// File: rtl/sw_debounce_pkg.sv
// Shared debounce constants.
// Keeps the board top and sim benches on the same stable-count values.
package sw_debounce_pkg;

  localparam int DB_STABLE_DEFAULT = 50000;
  localparam int DB_STABLE_SIM     = 4;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-side bundle: raw switch levels in, debounced levels and change strobe out.
// The master side drives the switches and the slave side is the debouncer.
interface sw_debounce_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] sw_raw;
  logic             en_raw;
  logic [WIDTH-1:0] x_db;
  logic             en_db;
  logic             chg;

  modport master (
    output sw_raw,
    output en_raw,
    input  x_db,
    input  en_db,
    input  chg
  );

  modport slave (
    input  sw_raw,
    input  en_raw,
    output x_db,
    output en_db,
    output chg
  );

endinterface

// File: rtl/sw_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, mismatch counter, output flop.
// q_flip is high in the cycle before q takes a new value.
module db_channel
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic q,
  output logic q_flip
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (s2_q != q_q) begin
      if (cnt_q == TERM) begin
        q_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      s1_q  <= d_raw;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q      = q_q;
  assign q_flip = q_d ^ q_q;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioner: WIDTH data channels plus one enable channel.
// chg is registered so it lines up with the cycle the new level appears.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = DB_STABLE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  sw_debounce_if.slave  bus
);

  logic [WIDTH:0] raw;
  logic [WIDTH:0] q;
  logic [WIDTH:0] flip;
  logic           chg_d, chg_q;

  // Enable rides as the top channel.
  assign raw = {bus.en_raw, bus.sw_raw};

  for (genvar g = 0; g <= WIDTH; g++) begin : g_ch
    db_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_raw  (raw[g]),
      .q      (q[g]),
      .q_flip (flip[g])
    );
  end

  always_comb begin
    chg_d = |flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign bus.x_db  = q[WIDTH-1:0];
  assign bus.en_db = q[WIDTH];
  assign bus.chg   = chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a window-based reference model.
// A channel flips once its last STABLE_CYCLES synchronised samples all disagree with it.
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int W = 8;
  localparam int S = DB_STABLE_SIM;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(
    .WIDTH        (W),
    .STABLE_CYCLES(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // hist[0] = raw seen at the previous edge, hist[1] = level compared now, ...
  logic [W:0] hist[$];
  logic [W:0] mout;
  logic       mchg;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_front('0);
    mout = '0;
    mchg = 1'b0;
  endtask

  // One clock edge; advances the model, then waits 1 time unit to sample.
  task automatic step();
    logic [W:0] r;
    logic [W:0] nxt;
    bit         all;
    @(posedge clk);
    r   = {bus.en_raw, bus.sw_raw};
    nxt = mout;
    if (rst_n) begin
      for (int b = 0; b <= W; b++) begin
        all = 1'b1;
        for (int i = 1; i <= S; i++)
          if (hist[i][b] == mout[b]) all = 1'b0;
        if (all) nxt[b] = ~mout[b];
      end
      mchg = |(nxt ^ mout);
      mout = nxt;
      hist.push_front(r);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    int edge_at, pulses;
    rst_n = 1'b0;
    bus.sw_raw = 8'hFF;
    bus.en_raw = 1'b1;
    model_reset();
    #2;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if ({bus.chg, bus.en_db, bus.x_db} !== 10'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d got %h exp 000", c,
                 {bus.chg, bus.en_db, bus.x_db});
      end
    end
    rst_n = 1'b1;
    edge_at = -1;
    pulses  = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.chg) pulses++;
      if (edge_at < 0 && bus.x_db == 8'hFF) edge_at = c;
      n_tests++;
      if ({bus.chg, bus.en_db, bus.x_db} !== {mchg, mout}) begin
        n_fail++;
        $display("FAIL reset_release cyc%0d got %h exp %h", c,
                 {bus.chg, bus.en_db, bus.x_db}, {mchg, mout});
      end
    end
    n_tests++;
    if (edge_at != S + 2 || pulses != 1 || bus.en_db !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_latency got edge %0d pulses %0d en %b exp edge %0d pulses 1 en 1",
               edge_at, pulses, bus.en_db, S + 2);
    end
  endtask

  task automatic settle(input logic [W-1:0] sw, input logic en);
    bus.sw_raw = sw;
    bus.en_raw = en;
    for (int c = 0; c < 3 * S; c++) step();
  endtask

  task automatic test_clean_edit();
    int edge_at, pulses;
    settle(8'h00, 1'b0);
    n_tests++;
    if (bus.x_db !== 8'h00 || bus.en_db !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_settle got %h/%b exp 00/0", bus.x_db, bus.en_db);
    end
    bus.sw_raw = 8'h10;
    edge_at = -1;
    pulses  = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.chg) begin
        pulses++;
        n_tests++;
        if (bus.x_db !== 8'h10) begin
          n_fail++;
          $display("FAIL clean_chg_align got %h exp 10", bus.x_db);
        end
      end
      if (edge_at < 0 && bus.x_db == 8'h10) edge_at = c;
      n_tests++;
      if ({bus.chg, bus.en_db, bus.x_db} !== {mchg, mout}) begin
        n_fail++;
        $display("FAIL clean_model cyc%0d got %h exp %h", c,
                 {bus.chg, bus.en_db, bus.x_db}, {mchg, mout});
      end
    end
    n_tests++;
    if (edge_at != S + 2 || pulses != 1) begin
      n_fail++;
      $display("FAIL clean_latency got edge %0d pulses %0d exp %0d/1",
               edge_at, pulses, S + 2);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    bit seen;
    settle(8'h00, 1'b0);
    pulses = 0;
    bus.sw_raw = 8'h08;
    for (int c = 0; c < 12; c++) begin
      if (c == S - 1) bus.sw_raw = 8'h00;
      step();
      if (bus.chg) pulses++;
      n_tests++;
      if (bus.x_db !== 8'h00 || bus.x_db !== mout[W-1:0]) begin
        n_fail++;
        $display("FAIL glitch_short cyc%0d got %h exp 00", c, bus.x_db);
      end
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL glitch_chg got %0d pulses exp 0", pulses);
    end
    seen = 1'b0;
    bus.sw_raw = 8'h08;
    for (int c = 0; c < 12; c++) begin
      if (c == S) bus.sw_raw = 8'h00;
      step();
      if (bus.x_db[3]) seen = 1'b1;
      n_tests++;
      if ({bus.chg, bus.en_db, bus.x_db} !== {mchg, mout}) begin
        n_fail++;
        $display("FAIL glitch_long cyc%0d got %h exp %h", c,
                 {bus.chg, bus.en_db, bus.x_db}, {mchg, mout});
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL glitch_long_set got 0 exp 1");
    end
  endtask

  task automatic test_bounce();
    int edge_at, pulses;
    settle(8'h00, 1'b0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      bus.sw_raw[7] = c[1] ? 1'b0 : 1'b1;
      step();
      if (bus.chg) pulses++;
      n_tests++;
      if (bus.x_db[7] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_hold cyc%0d got %b exp 0", c, bus.x_db[7]);
      end
    end
    bus.sw_raw[7] = 1'b1;
    edge_at = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.chg) pulses++;
      if (edge_at < 0 && bus.x_db[7]) edge_at = c;
    end
    n_tests++;
    if (edge_at != S + 2 || pulses != 1 || mout[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_final got edge %0d pulses %0d exp %0d/1",
               edge_at, pulses, S + 2);
    end
  endtask

  task automatic test_simultaneous();
    int x_at, e_at, pulses;
    settle(8'h00, 1'b0);
    bus.sw_raw = 8'h81;
    bus.en_raw = 1'b1;
    x_at = -1;
    e_at = -1;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.chg) pulses++;
      if (x_at < 0 && bus.x_db == 8'h81) x_at = c;
      if (e_at < 0 && bus.en_db) e_at = c;
    end
    n_tests++;
    if (x_at != S + 2 || e_at != S + 2 || pulses != 1) begin
      n_fail++;
      $display("FAIL simultaneous got x %0d en %0d pulses %0d exp %0d/%0d/1",
               x_at, e_at, pulses, S + 2, S + 2);
    end
  endtask

  task automatic test_async_reset();
    int edge_at, pulses;
    settle(8'h00, 1'b0);
    bus.sw_raw = 8'h20;
    step();
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({bus.chg, bus.en_db, bus.x_db} !== 10'h0) begin
      n_fail++;
      $display("FAIL async_clear got %h exp 000", {bus.chg, bus.en_db, bus.x_db});
    end
    step();
    step();
    rst_n = 1'b1;
    edge_at = -1;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.chg) pulses++;
      if (edge_at < 0 && bus.x_db[5]) edge_at = c;
      n_tests++;
      if ({bus.chg, bus.en_db, bus.x_db} !== {mchg, mout}) begin
        n_fail++;
        $display("FAIL async_model cyc%0d got %h exp %h", c,
                 {bus.chg, bus.en_db, bus.x_db}, {mchg, mout});
      end
    end
    n_tests++;
    if (edge_at != S + 2 || pulses != 1) begin
      n_fail++;
      $display("FAIL async_latency got edge %0d pulses %0d exp %0d/1",
               edge_at, pulses, S + 2);
    end
  endtask

  task automatic test_random();
    logic [W:0] r;
    r = {bus.en_raw, bus.sw_raw};
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, W)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) r = W'($urandom);
      {bus.en_raw, bus.sw_raw} = r;
      step();
      n_tests++;
      if ({bus.chg, bus.en_db, bus.x_db} !== {mchg, mout}) begin
        n_fail++;
        $display("FAIL random cyc%0d got %h exp %h", c,
                 {bus.chg, bus.en_db, bus.x_db}, {mchg, mout});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edit();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
